// File: rtl/sync_fifo_x_pkg.sv
// sync_fifo_x_pkg: shared constants and helpers for sync_fifo_x.
// Holds the read-mode encodings and the modulo-DEEP pointer step.
package sync_fifo_x_pkg;

  localparam int FWFT_STD  = 0;
  localparam int FWFT_FALL = 1;

  // Step a pointer, wrapping at DEEP-1 so odd depths work.
  function automatic int unsigned ptr_inc(
    input int unsigned ptr,
    input int unsigned deep
  );
    return (ptr >= deep - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_x_ram.sv
// sync_fifo_x_ram: DEEP x BITWID register array for sync_fifo_x.
// One synchronous write port, one asynchronous read port.
module sync_fifo_x_ram #(
  parameter int DEEPWID = 3,
  parameter int DEEP    = 8,
  parameter int BITWID  = 5
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEEPWID-1:0] waddr,
  input  logic [BITWID-1:0]  wdat,
  input  logic [DEEPWID-1:0] raddr,
  output logic [BITWID-1:0]  rdat
);

  logic [BITWID-1:0] mem [DEEP];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  assign rdat = mem[raddr];

endmodule

// File: rtl/sync_fifo_x.sv
// sync_fifo_x: synchronous FIFO, standard or first-word-fall-through.
// Define SYNC_FIFO_X_ERR_EN for sticky overflow/underflow flags.
module sync_fifo_x
  import sync_fifo_x_pkg::*;
#(
  parameter int DEEPWID = 3,
  parameter int DEEP    = 8,
  parameter int BITWID  = 5,
  parameter int FWFT    = FWFT_STD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               wr,
  input  logic [BITWID-1:0]  wr_dat,
  input  logic               rd,
  output logic [BITWID-1:0]  rd_dat,
  output logic               rd_dat_vld,
  input  logic [DEEPWID:0]   cfg_almost_full,
  input  logic [DEEPWID:0]   cfg_almost_empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic               full,
  output logic               empty,
  output logic [DEEPWID:0]   fifo_num,
  input  logic               clr_err,
  output logic               overflow,
  output logic               underflow
);

  localparam logic [DEEPWID:0] CNT_MAX = (DEEPWID+1)'(DEEP);
  localparam logic [DEEPWID:0] CNT_ONE = (DEEPWID+1)'(1);

  logic [DEEPWID-1:0] wr_ptr;
  logic [DEEPWID-1:0] rd_ptr;
  logic [DEEPWID-1:0] wr_ptr_inc;
  logic [DEEPWID-1:0] rd_ptr_inc;
  logic [DEEPWID:0]   cnt;
  logic [DEEPWID:0]   cnt_nxt;
  logic [BITWID-1:0]  ram_dat;
  logic               rd_acc;
  logic               wr_acc;

  // Flush wins over both requests; a full FIFO still takes a write
  // when the same cycle pops, since the popped slot frees up.
  assign rd_acc = rd && !empty && !flush;
  assign wr_acc = wr && (!full || rd_acc) && !flush;

  assign wr_ptr_inc = DEEPWID'(ptr_inc(32'(wr_ptr), DEEP));
  assign rd_ptr_inc = DEEPWID'(ptr_inc(32'(rd_ptr), DEEP));

  always_comb begin
    cnt_nxt = cnt;
    if (flush) cnt_nxt = '0;
    else if (wr_acc && !rd_acc) cnt_nxt = cnt + CNT_ONE;
    else if (rd_acc && !wr_acc) cnt_nxt = cnt - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= (cfg_almost_full == '0);
      almost_empty <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr_inc;
        if (rd_acc) rd_ptr <= rd_ptr_inc;
      end
      cnt          <= cnt_nxt;
      full         <= (cnt_nxt == CNT_MAX);
      empty        <= (cnt_nxt == '0);
      almost_full  <= (cnt_nxt >= cfg_almost_full);
      almost_empty <= (cnt_nxt <= cfg_almost_empty);
    end
  end

  assign fifo_num = cnt;

  sync_fifo_x_ram #(
    .DEEPWID (DEEPWID),
    .DEEP    (DEEP),
    .BITWID  (BITWID)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc && rst_n),
    .waddr (wr_ptr),
    .wdat  (wr_dat),
    .raddr (rd_ptr),
    .rdat  (ram_dat)
  );

  if (FWFT == FWFT_FALL) begin : g_fwft
    assign rd_dat     = empty ? '0 : ram_dat;
    assign rd_dat_vld = !empty;
  end else begin : g_std
    logic [BITWID-1:0] dat_q;
    logic              vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dat_q <= '0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= rd_acc;
        if (rd_acc) dat_q <= ram_dat;
      end
    end

    assign rd_dat     = dat_q;
    assign rd_dat_vld = vld_q;
  end

`ifdef SYNC_FIFO_X_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr_err) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full && !rd) overflow  <= 1'b1;
      if (rd && empty)       underflow <= 1'b1;
    end
  end
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_x.sv
// tb_sync_fifo_x: directed vectors and scoreboard runs for sync_fifo_x.
// Instance a: DEEP=8 standard read; instance b: DEEP=6 FWFT.
module tb_sync_fifo_x;

`ifdef SYNC_FIFO_X_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_flush, a_wr, a_rd, a_clr;
  logic [4:0] a_wdat, a_rdat;
  logic       a_vld, a_af, a_ae, a_full, a_empty, a_ovf, a_uf;
  logic [3:0] a_caf, a_cae, a_num;

  logic       b_flush, b_wr, b_rd, b_clr;
  logic [4:0] b_wdat, b_rdat;
  logic       b_vld, b_af, b_ae, b_full, b_empty, b_ovf, b_uf;
  logic [3:0] b_caf, b_cae, b_num;

  sync_fifo_x #(.DEEPWID(3), .DEEP(8), .BITWID(5), .FWFT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .wr(a_wr), .wr_dat(a_wdat), .rd(a_rd),
    .rd_dat(a_rdat), .rd_dat_vld(a_vld),
    .cfg_almost_full(a_caf), .cfg_almost_empty(a_cae),
    .almost_full(a_af), .almost_empty(a_ae),
    .full(a_full), .empty(a_empty), .fifo_num(a_num),
    .clr_err(a_clr), .overflow(a_ovf), .underflow(a_uf)
  );

  sync_fifo_x #(.DEEPWID(3), .DEEP(6), .BITWID(5), .FWFT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .wr(b_wr), .wr_dat(b_wdat), .rd(b_rd),
    .rd_dat(b_rdat), .rd_dat_vld(b_vld),
    .cfg_almost_full(b_caf), .cfg_almost_empty(b_cae),
    .almost_full(b_af), .almost_empty(b_ae),
    .full(b_full), .empty(b_empty), .fifo_num(b_num),
    .clr_err(b_clr), .overflow(b_ovf), .underflow(b_uf)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [4:0] d;
    logic       rd;
    logic       fl;
    logic       clr;
    int         num;
    logic       vld;
    logic [4:0] dat;
    logic       ovf;
    logic       uf;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic wr, logic [4:0] d, logic rd,
                              logic fl, logic clr, int num, logic vld,
                              logic [4:0] dat, logic ovf, logic uf);
    vec_t v;
    v.wr = wr; v.d = d; v.rd = rd; v.fl = fl; v.clr = clr;
    v.num = num; v.vld = vld; v.dat = dat; v.ovf = ovf; v.uf = uf;
    return v;
  endfunction

  // Flags of instance a follow from the count with cfg 6 / 2.
  task automatic check_a(input string t, input int num, input logic vld,
                         input logic [4:0] dat, input logic ovf,
                         input logic uf);
    chk({t, " num"}, 32'(a_num), 32'(num));
    chk({t, " full"}, 32'(a_full), 32'(num == 8));
    chk({t, " empty"}, 32'(a_empty), 32'(num == 0));
    chk({t, " afull"}, 32'(a_af), 32'(num >= 6));
    chk({t, " aempty"}, 32'(a_ae), 32'(num <= 2));
    chk({t, " vld"}, 32'(a_vld), 32'(vld));
    chk({t, " dat"}, 32'(a_rdat), 32'(dat));
    chk({t, " ovf"}, 32'(a_ovf), 32'(ERR & ovf));
    chk({t, " uf"}, 32'(a_uf), 32'(ERR & uf));
  endtask

  task automatic b_step(input logic w, input logic [4:0] d,
                        input logic r);
    b_wr = w; b_wdat = d; b_rd = r;
    @(negedge clk);
    b_wr = 1'b0; b_rd = 1'b0;
  endtask

  logic [4:0] q[$];
  logic [4:0] qb[$];
  logic [4:0] ed, dd;
  logic       ev, w, r, fl, racc, wacc;

  initial begin
    a_flush = 0; a_wr = 0; a_rd = 0; a_clr = 0; a_wdat = 0;
    a_caf = 4'd6; a_cae = 4'd2;
    b_flush = 0; b_wr = 0; b_rd = 0; b_clr = 0; b_wdat = 0;
    b_caf = 4'd6; b_cae = 4'd0;

    #12;
    check_a("rst", 0, 0, 0, 0, 0);
    chk("b rst vld", 32'(b_vld), 0);
    chk("b rst empty", 32'(b_empty), 1);
    chk("b rst aempty", 32'(b_ae), 1);
    chk("b rst afull", 32'(b_af), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 1; k <= 8; k++)
      tv.push_back(mk(1, 5'(k), 0, 0, 0, k, 0, 0, 0, 0));
    tv.push_back(mk(1, 9, 0, 0, 0, 8, 0, 0, 1, 0));
    tv.push_back(mk(1, 31, 1, 0, 0, 8, 1, 1, 1, 0));
    for (int k = 2; k <= 8; k++)
      tv.push_back(mk(0, 0, 1, 0, 0, 9 - k, 1, 5'(k), 1, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 0, 1, 31, 1, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, 31, 1, 1));
    tv.push_back(mk(1, 5, 1, 0, 0, 1, 0, 31, 1, 1));
    tv.push_back(mk(1, 6, 1, 1, 0, 0, 0, 31, 1, 1));
    tv.push_back(mk(0, 0, 1, 0, 1, 0, 0, 31, 0, 0));
    tv.push_back(mk(1, 3, 0, 0, 0, 1, 0, 31, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 0, 1, 3, 0, 0));

    foreach (tv[i]) begin
      a_wr = tv[i].wr; a_wdat = tv[i].d; a_rd = tv[i].rd;
      a_flush = tv[i].fl; a_clr = tv[i].clr;
      @(negedge clk);
      check_a($sformatf("v%0d", i), tv[i].num, tv[i].vld,
              tv[i].dat, tv[i].ovf, tv[i].uf);
    end
    a_wr = 0; a_rd = 0; a_flush = 0; a_clr = 0;

    b_step(1, 7, 0);
    chk("b fwft vld", 32'(b_vld), 1);
    chk("b fwft dat", 32'(b_rdat), 7);
    chk("b fwft num", 32'(b_num), 1);
    b_step(0, 0, 1);
    chk("b pop vld", 32'(b_vld), 0);
    chk("b pop empty", 32'(b_empty), 1);

    for (int k = 0; k < 6; k++) begin
      b_step(1, 5'(10 + k), 0);
      qb.push_back(5'(10 + k));
    end
    chk("b fill full", 32'(b_full), 1);
    chk("b fill num", 32'(b_num), 6);
    chk("b fill afull", 32'(b_af), 1);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("b wrap%0d dat", k), 32'(b_rdat), 32'(qb[0]));
      chk($sformatf("b wrap%0d vld", k), 32'(b_vld), 1);
      b_step(1, 5'(16 + k), 1);
      void'(qb.pop_front());
      qb.push_back(5'(16 + k));
      chk($sformatf("b wrap%0d num", k), 32'(b_num), 6);
    end
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("b drain%0d dat", k), 32'(b_rdat), 32'(qb[0]));
      b_step(0, 0, 1);
      void'(qb.pop_front());
    end
    chk("b drain empty", 32'(b_empty), 1);
    chk("b drain vld", 32'(b_vld), 0);

    void'($urandom(100));
    for (int c = 0; c < 10000; c++) begin
      fl = (c == 5000);
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      dd = 5'($urandom_range(0, 31));
      a_flush = fl; a_wr = w; a_rd = r; a_wdat = dd;
      ev = 1'b0;
      if (fl) begin
        q.delete();
      end else begin
        racc = r && (q.size() != 0);
        wacc = w && ((q.size() < 8) || racc);
        if (racc) begin
          ed = q.pop_front();
          ev = 1'b1;
        end
        if (wacc) q.push_back(dd);
      end
      @(negedge clk);
      chk($sformatf("rnd%0d num", c), 32'(a_num), 32'(q.size()));
      chk($sformatf("rnd%0d vld", c), 32'(a_vld), 32'(ev));
      if (ev) chk($sformatf("rnd%0d dat", c), 32'(a_rdat), 32'(ed));
      chk($sformatf("rnd%0d full", c), 32'(a_full), 32'(q.size() == 8));
      chk($sformatf("rnd%0d empty", c), 32'(a_empty), 32'(q.size() == 0));
      chk($sformatf("rnd%0d afull", c), 32'(a_af), 32'(q.size() >= 6));
      chk($sformatf("rnd%0d aempty", c), 32'(a_ae), 32'(q.size() <= 2));
    end
    a_flush = 0; a_rd = 0;
    a_wr = 1; a_wdat = 4;
    @(negedge clk);
    @(negedge clk);
    chk("mid pre num", 32'(a_num), 32'(q.size() + 2 > 8 ? 8 : q.size() + 2));

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst num", 32'(a_num), 0);
    chk("mid rst empty", 32'(a_empty), 1);
    chk("mid rst vld", 32'(a_vld), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    a_wr = 0;
    @(negedge clk);
    check_a("post rst", 0, 0, 0, 0, 0);
    chk("post rst b num", 32'(b_num), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
